// File: rtl/fetch_ir_unit_pkg.sv
// Shared types and constants for the fetch / instruction-register unit.
// Holds the fetch state encoding, the reset defaults and the alignment helper.
package fetch_ir_unit_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  // DRAIN is a WAIT whose response will be thrown away after a redirect
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return pc_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ir_unit_pc_register.sv
// Program counter: XLEN-bit register with write enable and async reset.
module fetch_ir_unit_pc_register #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_PC;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_ir_unit.sv
// Fetch unit: owns the PC and IR, issues one instruction read per fetch_start
// over a valid/ready request channel and tolerates redirects mid-fetch.
module fetch_ir_unit
  import fetch_ir_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_next,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] ir_out,
  output logic            ir_valid,
  output logic            busy,
  output logic            fetch_fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] eff_pc;
  logic            eff_pc_ok;

  logic            drop_q, drop_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            req_valid_q, req_valid_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;
  logic            resp_keep;

  fetch_ir_unit_pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk   (clk),
    .reset (reset),
    .we    (pc_write),
    .d     (pc_next),
    .q     (pc_q)
  );

  // A redirect in the same cycle as fetch_start is applied first
  always_comb begin
    eff_pc    = pc_write ? pc_next : pc_q;
    eff_pc_ok = pc_aligned(eff_pc[1:0]);
  end

  // Response is kept only in a clean WAIT with no redirect this cycle
  always_comb begin
    resp_keep = (state_q == ST_WAIT) && mem_resp_valid && !pc_write && !drop_q;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_start && eff_pc_ok) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = (drop_q || pc_write) ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_d = ST_IDLE;
        end else if (pc_write) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values, registered below
  always_comb begin
    drop_d     = drop_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    fault_d    = fault_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_start) begin
          if (eff_pc_ok) begin
            addr_d     = eff_pc;
            ir_valid_d = 1'b0;
            drop_d     = 1'b0;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        if (pc_write) begin
          drop_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (resp_keep) begin
      ir_d       = mem_resp_data;
      ir_valid_d = 1'b1;
    end

    // The IR never describes a freshly redirected PC
    if (pc_write) begin
      ir_valid_d = 1'b0;
    end

    if (state_d == ST_IDLE) begin
      drop_d = 1'b0;
    end

    req_valid_d = (state_d == ST_REQ);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q      <= 1'b0;
      addr_q      <= RESET_PC;
      ir_q        <= XLEN'(NOP_INST);
      ir_valid_q  <= 1'b0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      drop_q      <= drop_d;
      addr_q      <= addr_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = addr_q;
  assign pc_out        = pc_q;
  assign ir_out        = ir_q;
  assign ir_valid      = ir_valid_q;
  assign busy          = busy_q;
  assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_fetch_ir_unit.sv
// Bench for fetch_ir_unit: directed scenarios then random traffic, all checked
// against a transaction-level model of the fetch unit.
module tb_fetch_ir_unit;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset;
  logic            fetch_start;
  logic            pc_write;
  logic [XLEN-1:0] pc_next;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] ir_out;
  logic            ir_valid;
  logic            busy;
  logic            fetch_fault;

  int errors = 0;
  int checks = 0;

  fetch_ir_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_start    (fetch_start),
    .pc_write       (pc_write),
    .pc_next        (pc_next),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .pc_out         (pc_out),
    .ir_out         (ir_out),
    .ir_valid       (ir_valid),
    .busy           (busy),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: a fetch is either awaiting acceptance,
  // awaiting its response, or absent; 'dropped' marks a redirected fetch.
  logic [31:0] m_pc, m_ir, m_addr;
  logic        m_irv, m_fault, m_req_pending, m_resp_pending, m_dropped;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc           = RESET_PC;
    m_ir           = NOP;
    m_addr         = 32'h0;
    m_irv          = 1'b0;
    m_fault        = 1'b0;
    m_req_pending  = 1'b0;
    m_resp_pending = 1'b0;
    m_dropped      = 1'b0;
  endtask

  task automatic model_step(input logic fs, input logic pw, input logic [31:0] pn,
                            input logic rdy, input logic rv, input logic [31:0] rd);
    logic [31:0] target;
    if (!m_req_pending && !m_resp_pending) begin
      if (fs) begin
        target = pw ? pn : m_pc;
        if (target[1:0] != 2'b00) begin
          m_fault = 1'b1;
        end else begin
          m_req_pending = 1'b1;
          m_addr        = target;
          m_irv         = 1'b0;
          m_dropped     = 1'b0;
        end
      end
    end else if (m_req_pending) begin
      if (pw) m_dropped = 1'b1;
      if (rdy) begin
        m_req_pending  = 1'b0;
        m_resp_pending = 1'b1;
      end
    end else begin
      if (rv) begin
        if (!m_dropped && !pw) begin
          m_ir  = rd;
          m_irv = 1'b1;
        end
        m_resp_pending = 1'b0;
        m_dropped      = 1'b0;
      end else if (pw) begin
        m_dropped = 1'b1;
      end
    end
    if (pw) begin
      m_pc  = pn;
      m_irv = 1'b0;
    end
  endtask

  task automatic check_all();
    check_eq("mem_req_valid", 32'(mem_req_valid), 32'(m_req_pending));
    if (m_req_pending) check_eq("mem_req_addr", mem_req_addr, m_addr);
    check_eq("busy", 32'(busy), 32'(m_req_pending | m_resp_pending));
    check_eq("pc_out", pc_out, m_pc);
    check_eq("ir_out", ir_out, m_ir);
    check_eq("ir_valid", 32'(ir_valid), 32'(m_irv));
    check_eq("fetch_fault", 32'(fetch_fault), 32'(m_fault));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare
  task automatic cycle(input logic fs, input logic pw, input logic [31:0] pn,
                       input logic rdy, input logic rv, input logic [31:0] rd);
    fetch_start    = fs;
    pc_write       = pw;
    pc_next        = pn;
    mem_req_ready  = rdy;
    mem_resp_valid = rv;
    mem_resp_data  = rd;
    @(posedge clk);
    model_step(fs, pw, pn, rdy, rv, rd);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    fetch_start    = 1'b0;
    pc_write       = 1'b0;
    pc_next        = 32'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
  endtask

  // Reset pulse placed strictly between clock edges
  task automatic async_reset();
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("arst_req_valid", 32'(mem_req_valid), 32'h0);
    check_eq("arst_pc", pc_out, RESET_PC);
    check_all();
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] pn;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #3;
    check_eq("rst_pc", pc_out, 32'h0);
    check_eq("rst_ir", ir_out, 32'h0000_0013);
    check_eq("rst_ir_valid", 32'(ir_valid), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_all();
    #9 reset = 1'b0;

    // Basic fetch, minimum latency
    cycle(1, 0, 0, 0, 0, 0);
    check_eq("t1_addr", mem_req_addr, 32'h0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h0050_0093);
    check_eq("t1_ir", ir_out, 32'h0050_0093);
    check_eq("t1_ir_valid", 32'(ir_valid), 32'h1);

    // Backpressure
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      check_eq("t2_hold_valid", 32'(mem_req_valid), 32'h1);
      check_eq("t2_hold_addr", mem_req_addr, 32'h0);
      check_eq("t2_busy", 32'(busy), 32'h1);
    end
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'hFE00_0EE3);
    check_eq("t2_ir", ir_out, 32'hFE00_0EE3);
    cycle(0, 0, 0, 0, 0, 0);
    check_eq("t2_no_second_req", 32'(mem_req_valid), 32'h0);

    // Redirect while waiting for the response
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h40, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check_eq("t3_ir_kept", ir_out, 32'hFE00_0EE3);
    check_eq("t3_ir_valid", 32'(ir_valid), 32'h0);
    check_eq("t3_pc", pc_out, 32'h40);
    cycle(1, 0, 0, 0, 0, 0);
    check_eq("t3_addr", mem_req_addr, 32'h40);

    // Redirect coincident with the response
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h80, 0, 1, 32'h1234_5678);
    check_eq("t4_pc", pc_out, 32'h80);
    check_eq("t4_ir_valid", 32'(ir_valid), 32'h0);
    check_eq("t4_ir_kept", ir_out, 32'hFE00_0EE3);

    // Misaligned fetch: sticky fault
    cycle(0, 1, 32'h42, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check_eq("t5_no_req", 32'(mem_req_valid), 32'h0);
    check_eq("t5_fault", 32'(fetch_fault), 32'h1);
    cycle(1, 1, 32'h100, 0, 0, 0);
    check_eq("t5_new_addr", mem_req_addr, 32'h100);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h0000_0073);
    check_eq("t5_fault_sticky", 32'(fetch_fault), 32'h1);

    // Reset in the middle of a request, then a stray response
    cycle(1, 0, 0, 0, 0, 0);
    async_reset();
    check_eq("t6_fault_clear", 32'(fetch_fault), 32'h0);
    cycle(0, 0, 0, 0, 1, 32'hCAFE_F00D);
    check_eq("t6_stray", 32'(ir_valid), 32'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        pn = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 39) == 0) pn[1:0] = 2'($urandom_range(1, 3));
        cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) < 3), pn,
              ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5), $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ir_unit.md
Name: fetch_ir_unit

Overview:
Owns the program counter and the instruction register (IR) of the multi-cycle core. On request from the control FSM it issues one instruction-memory read using a valid/ready request and a valid response. It latches the returned word into the IR and holds it stable for the decode stage, the immediate generator and the register-file address fields. It also accepts PC redirects, including redirects that arrive while a fetch is outstanding.

Parameters:
XLEN, 32, datapath/instruction width.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  core clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
fetch_start  in  1  control FSM pulse: fetch the instruction at the current PC.
pc_write  in  1  load pc_next into PC (sequential increment or branch/jump target).
pc_next  in  XLEN  next PC value.
mem_req_valid  out  1  instruction-memory read request.
mem_req_addr  out  XLEN  request address (the PC captured at issue).
mem_req_ready  in  1  memory accepts the request this cycle.
mem_resp_valid  in  1  read data valid, one pulse per accepted request.
mem_resp_data  in  XLEN  instruction word.
pc_out  out  XLEN  current PC.
ir_out  out  XLEN  latched instruction, routed to decode and the immediate generator.
ir_valid  out  1  ir_out holds a completed fetch for the current PC.
busy  out  1  fetch in progress (REQ, WAIT or DRAIN).
fetch_fault  out  1  sticky: a fetch was attempted at a misaligned PC.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, PC=RESET_PC, ir_out=32'h0000_0013 (NOP), ir_valid=0, mem_req_valid=0, busy=0, fetch_fault=0, drop flag=0.
- A reset asserted mid-fetch abandons the transaction. Any late mem_resp_valid after reset deasserts is ignored because the state is IDLE.
- IDLE:
  - If fetch_start and PC[1:0]!=0: set fetch_fault, stay IDLE, no request.
  - If fetch_start and PC aligned: go to REQ. Clear ir_valid in the same edge.
- REQ:
  - mem_req_valid=1 and mem_req_addr=PC, captured into an address register on entry; both hold until accepted.
  - mem_req_ready=1 → WAIT.
- WAIT:
  - mem_resp_valid=1 → ir_out<=mem_resp_data, ir_valid<=1, go to IDLE.
  - Latency from fetch_start to ir_valid is 3 cycles minimum: 1 cycle in REQ with ready high, 1 cycle in WAIT with the response, then registered.
- pc_write:
  - Accepted in every state. PC<=pc_next on that edge.
  - In REQ the request address is already captured, so the redirect does not change an unaccepted request.
  - Also clears ir_valid, since the IR no longer matches the PC.
- Redirect during an outstanding fetch:
  - pc_write in REQ or WAIT sets the drop flag.
  - On arrival, the response is discarded and the IR is unchanged. The FSM goes to IDLE with ir_valid=0, and control must re-issue fetch_start.
  - pc_write in the same cycle as mem_resp_valid in WAIT: the response is discarded (redirect wins).
- fetch_start while busy: ignored. No queueing; control must wait for busy=0.
- fetch_start and pc_write in the same IDLE cycle: the PC updates first. The fetch uses the new PC from the next cycle, and the alignment check is applied to pc_next.
- mem_resp_valid outside WAIT: ignored.
- fetch_fault stays set until reset.
- PC arithmetic: none internal. The increment is supplied by the datapath through pc_next, with XLEN-bit wrap-around implied.
- ir_out is constant except on a non-dropped response.

Decomposition:
- Shared package/defines:
  - fetch state encoding IDLE/REQ/WAIT/DRAIN (DRAIN = WAIT with the drop flag set; may be implemented as a flag instead).
  - NOP_INST constant.
  - RESET_PC default.
- One natural sub-module: pc_register (async-reset XLEN register with write enable, reset value RESET_PC).
- The IR and FSM stay in the top.

Test Plan:
1. Reset → pc_out=0, ir_out=32'h00000013, ir_valid=0, busy=0; fetch_start with ready=1 and response 32'h00500093 one cycle later → mem_req_addr=0, ir_out=32'h00500093, ir_valid=1 at cycle 3.
2. Backpressure: ready low for 4 cycles → mem_req_valid held, mem_req_addr=0 stable, busy=1; then ready=1 and response 32'hFE000EE3 → IR latched once, no second request.
3. Redirect in WAIT: pc_write with pc_next=32'h40 while the response is pending → response 32'hDEADBEEF discarded, ir_out unchanged, ir_valid=0, pc_out=32'h40; next fetch_start → mem_req_addr=32'h40.
4. Simultaneous pc_write and mem_resp_valid in WAIT → response dropped, PC=pc_next, ir_valid=0.
5. Misaligned: pc_write 32'h42, fetch_start → no mem_req_valid, fetch_fault=1 and stays 1 across later aligned fetches until reset.
6. Asynchronous reset asserted in REQ (between clock edges) → mem_req_valid=0 and PC=RESET_PC immediately; a stray mem_resp_valid after release leaves ir_valid=0.
